// File: rtl/pac_flash_saver.sv
// Copies the PAC SRAM image from SD-RAM to flash: erase each 4KB sector, then fill, program and poll each 256B page.
// Latency is set by the RAM/flash handshakes; RAM_OE and FLASH_REQ are held until acknowledged, and RD pulses pace program data.
module pac_flash_saver #(
    parameter logic [23:0] RAM_BASE   = 24'h77_E000,
    parameter logic [23:0] FLASH_BASE = 24'h1F_0000,
    parameter int          SAVE_SIZE  = 8192,
    parameter logic [19:0] POLL_LIMIT = 20'hF_FFFF
) (
    input  logic        CLK,
    input  logic        RESET_n,
    input  logic        START,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERROR,
    output logic [23:0] RAM_ADDR,
    output logic        RAM_OE,
    input  logic        RAM_ACK,
    input  logic [7:0]  RAM_RDATA,
    output logic        FLASH_REQ,
    output logic [1:0]  FLASH_OP,
    output logic [23:0] FLASH_ADDR,
    input  logic        FLASH_ACK,
    input  logic [7:0]  FLASH_RDATA,
    input  logic        FLASH_WDATA_RD,
    output logic [7:0]  FLASH_WDATA
);

    localparam logic [6:0] NUM_PAGES = 7'(SAVE_SIZE / 256);

    typedef enum logic [2:0] {
        S_IDLE, S_ERASE, S_EPOLL, S_FILL, S_PROG, S_PPOLL, S_FIN, S_ERR
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  sector_q, sector_d;
    logic [5:0]  page_q, page_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  wptr_q, wptr_d;
    logic [19:0] poll_q, poll_d;
    logic        req_q, req_d;
    logic        oe_q, oe_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic [7:0]  wdata_q;
    logic        buf_we;
    logic [6:0]  page_nxt;
    logic [7:0]  buf_mem [256];
    logic        unused_status;

    // Only the WIP bit of the status byte matters here.
    assign unused_status = ^FLASH_RDATA[7:1];
    assign page_nxt      = {1'b0, page_q} + 7'd1;

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q  <= S_IDLE;
            sector_q <= '0;
            page_q   <= '0;
            idx_q    <= '0;
            wptr_q   <= '0;
            poll_q   <= '0;
            req_q    <= 1'b0;
            oe_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            sector_q <= sector_d;
            page_q   <= page_d;
            idx_q    <= idx_d;
            wptr_q   <= wptr_d;
            poll_q   <= poll_d;
            req_q    <= req_d;
            oe_q     <= oe_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            error_q  <= error_d;
            if (state_d == S_PROG)
                wdata_q <= buf_mem[wptr_d];
        end
    end

    always_ff @(posedge CLK) begin
        if (buf_we)
            buf_mem[idx_q] <= RAM_RDATA;
    end

    always_comb begin
        state_d  = state_q;
        sector_d = sector_q;
        page_d   = page_q;
        idx_d    = idx_q;
        wptr_d   = wptr_q;
        poll_d   = poll_q;
        req_d    = req_q;
        oe_d     = oe_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        error_d  = error_q;
        buf_we   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    sector_d = '0;
                    page_d   = '0;
                    error_d  = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = S_ERASE;
                end
            end
            S_ERASE, S_PROG: begin
                if (state_q == S_PROG && FLASH_WDATA_RD)
                    wptr_d = wptr_q + 8'd1;
                // Requests are raised only from a REQ=0 cycle, which guarantees the idle gap.
                if (!req_q) begin
                    req_d = 1'b1;
                end else if (FLASH_ACK) begin
                    req_d   = 1'b0;
                    poll_d  = '0;
                    state_d = (state_q == S_ERASE) ? S_EPOLL : S_PPOLL;
                end
            end
            S_EPOLL, S_PPOLL: begin
                if (!req_q) begin
                    req_d = 1'b1;
                end else if (FLASH_ACK) begin
                    req_d = 1'b0;
                    if (FLASH_RDATA[0]) begin
                        if (poll_q == POLL_LIMIT)
                            state_d = S_ERR;
                        else
                            poll_d = poll_q + 20'd1;
                    end else if (state_q == S_EPOLL) begin
                        idx_d   = '0;
                        state_d = S_FILL;
                    end else begin
                        page_d = page_nxt[5:0];
                        if (page_nxt == NUM_PAGES) begin
                            state_d = S_FIN;
                        end else if (page_nxt[3:0] == 4'd0) begin
                            sector_d = sector_q + 4'd1;
                            state_d  = S_ERASE;
                        end else begin
                            idx_d   = '0;
                            state_d = S_FILL;
                        end
                    end
                end
            end
            S_FILL: begin
                if (!oe_q) begin
                    oe_d = 1'b1;
                end else if (RAM_ACK) begin
                    buf_we = 1'b1;
                    oe_d   = 1'b0;
                    idx_d  = idx_q + 8'd1;
                    if (idx_q == 8'hFF) begin
                        wptr_d  = '0;
                        state_d = S_PROG;
                    end
                end
            end
            S_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            S_ERR: begin
                error_d = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        FLASH_OP   = 2'd0;
        FLASH_ADDR = '0;
        if (req_q) begin
            case (state_q)
                S_ERASE: FLASH_OP = 2'd1;
                S_PROG:  FLASH_OP = 2'd2;
                default: FLASH_OP = 2'd3;
            endcase
            if (state_q == S_ERASE || state_q == S_EPOLL)
                FLASH_ADDR = FLASH_BASE + {8'd0, sector_q, 12'd0};
            else
                FLASH_ADDR = FLASH_BASE + {10'd0, page_q, 8'd0};
        end
    end

    assign RAM_ADDR    = oe_q ? (RAM_BASE + {10'd0, page_q, idx_q}) : 24'd0;
    assign RAM_OE      = oe_q;
    assign FLASH_REQ   = req_q;
    assign FLASH_WDATA = wdata_q;
    assign BUSY        = busy_q;
    assign DONE        = done_q;
    assign ERROR       = error_q;

endmodule

// File: tb/tb_pac_flash_saver.sv
// Directed bench for pac_flash_saver: cycle vectors for the handshakes, then SD-RAM/flash models for whole saves.
module tb_pac_flash_saver;

    localparam logic [19:0] PL = 20'd6;

    logic        CLK, RESET_n, START;
    logic        BUSY, DONE, ERROR, RAM_OE, FLASH_REQ;
    logic [23:0] RAM_ADDR, FLASH_ADDR;
    logic [1:0]  FLASH_OP;
    logic [7:0]  FLASH_WDATA;
    logic        RAM_ACK, FLASH_ACK, FLASH_WDATA_RD;
    logic [7:0]  RAM_RDATA, FLASH_RDATA;

    logic        mdl_en, clr_req, stuck, bp;
    logic        t_ram_ack, t_flash_ack, m_ram_ack, m_flash_ack, m_rd;
    logic [7:0]  t_ram_rdata, t_flash_rdata, m_ram_rdata, m_flash_rdata;

    assign RAM_ACK        = mdl_en ? m_ram_ack : t_ram_ack;
    assign RAM_RDATA      = mdl_en ? m_ram_rdata : t_ram_rdata;
    assign FLASH_ACK      = mdl_en ? m_flash_ack : t_flash_ack;
    assign FLASH_RDATA    = mdl_en ? m_flash_rdata : t_flash_rdata;
    assign FLASH_WDATA_RD = mdl_en ? m_rd : 1'b0;

    pac_flash_saver #(.POLL_LIMIT(PL)) dut (
        .CLK(CLK), .RESET_n(RESET_n), .START(START), .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR),
        .RAM_ADDR(RAM_ADDR), .RAM_OE(RAM_OE), .RAM_ACK(RAM_ACK), .RAM_RDATA(RAM_RDATA),
        .FLASH_REQ(FLASH_REQ), .FLASH_OP(FLASH_OP), .FLASH_ADDR(FLASH_ADDR), .FLASH_ACK(FLASH_ACK),
        .FLASH_RDATA(FLASH_RDATA), .FLASH_WDATA_RD(FLASH_WDATA_RD), .FLASH_WDATA(FLASH_WDATA)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Model state, owned by the negedge model process.
    int          ram_wait, ram_count, ram_seq_bad;
    int          erase_count, prog_count, status_count, prog_bad, stab_bad, prog_rd, busy_polls, done_cnt;
    int          e2_ram, e2_prog, off;
    logic        last_wip, e2_wip, prev_rd, in_prog;
    logic [7:0]  prev_wd;
    logic [23:0] erase_addr [$];
    logic [7:0]  fmem [8192];

    always @(negedge CLK) begin
        m_ram_ack   = 1'b0;
        m_flash_ack = 1'b0;
        m_rd        = 1'b0;
        if (clr_req) begin
            ram_wait = 0; ram_count = 0; ram_seq_bad = 0;
            erase_count = 0; prog_count = 0; status_count = 0; prog_bad = 0; stab_bad = 0;
            prog_rd = 0; busy_polls = 0; done_cnt = 0; e2_ram = -1; e2_prog = -1;
            last_wip = 1'b1; e2_wip = 1'b1; prev_rd = 1'b1; in_prog = 1'b0; prev_wd = 8'h00;
            erase_addr.delete();
            for (int i = 0; i < 8192; i++) fmem[i] = 8'h00;
        end else if (!RESET_n) begin
            ram_wait = 0; prog_rd = 0; busy_polls = 0; in_prog = 1'b0;
        end else if (mdl_en) begin
            if (DONE) done_cnt++;
            if (RAM_OE) begin
                if (ram_wait > 0) begin
                    ram_wait--;
                end else begin
                    m_ram_ack   = 1'b1;
                    m_ram_rdata = RAM_ADDR[7:0] ^ RAM_ADDR[15:8];
                    if (RAM_ADDR != 24'h77_E000 + 24'(ram_count)) ram_seq_bad++;
                    ram_count++;
                    ram_wait = (bp && $urandom_range(15, 0) == 0) ? int'($urandom_range(20, 0)) : 0;
                end
            end
            if (FLASH_REQ) begin
                off = int'(FLASH_ADDR) - 32'h1F_0000;
                case (FLASH_OP)
                    2'd1: begin
                        m_flash_ack = 1'b1;
                        erase_count++;
                        erase_addr.push_back(FLASH_ADDR);
                        for (int i = 0; i < 4096; i++)
                            if (off + i >= 0 && off + i < 8192) fmem[off + i] = 8'hFF;
                        busy_polls = 3;
                        if (FLASH_ADDR == 24'h1F_1000) begin
                            e2_ram = ram_count; e2_prog = prog_count; e2_wip = last_wip;
                        end
                    end
                    2'd3: begin
                        m_flash_ack   = 1'b1;
                        last_wip      = stuck || (busy_polls > 0);
                        m_flash_rdata = {7'd0, last_wip};
                        if (busy_polls > 0) busy_polls--;
                        status_count++;
                    end
                    2'd2: begin
                        if (in_prog && !prev_rd && FLASH_WDATA !== prev_wd) stab_bad++;
                        in_prog = 1'b1;
                        prev_wd = FLASH_WDATA;
                        if (prog_rd < 256) begin
                            if (!bp || $urandom_range(3, 0) != 0) begin
                                m_rd = 1'b1;
                                if (off + prog_rd >= 0 && off + prog_rd < 8192) fmem[off + prog_rd] = FLASH_WDATA;
                                prog_rd++;
                            end
                        end else begin
                            m_flash_ack = 1'b1;
                            if (FLASH_ADDR != 24'h1F_0000 + 24'(prog_count * 256)) prog_bad++;
                            prog_count++;
                            prog_rd = 0;
                            busy_polls = 3;
                            in_prog = 1'b0;
                        end
                        prev_rd = m_rd;
                    end
                    default: prog_bad++;
                endcase
            end
        end
    end

    function automatic int data_bad();
        int n;
        logic [23:0] a;
        n = 0;
        for (int i = 0; i < 8192; i++) begin
            a = 24'h77_E000 + 24'(i);
            if (fmem[i] !== (a[7:0] ^ a[15:8])) n++;
        end
        return n;
    endfunction

    task automatic clear_models();
        @(posedge CLK); clr_req = 1'b1;
        @(posedge CLK); clr_req = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge CLK); START = 1'b1;
        @(negedge CLK); START = 1'b0;
    endtask

    logic busy_at_end;

    task automatic wait_end(input int budget, input bit poke, output bit ok);
        bit poked;
        poked = 1'b0;
        ok    = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge CLK);
            if (poke && !poked && ram_count >= 5 * 256 + 10) begin
                START = 1'b1;
                poked = 1'b1;
            end else begin
                START = 1'b0;
            end
            if (DONE || ERROR) begin
                busy_at_end = BUSY;
                ok = 1'b1;
                START = 1'b0;
                return;
            end
        end
    endtask

    task automatic check_save(input string p, input bit ok);
        repeat (5) @(negedge CLK);
        check({p, "_finished"}, 64'(ok), 64'd1);
        check({p, "_busy_with_done"}, 64'(busy_at_end), 64'd0);
        check({p, "_erases"}, 64'(erase_count), 64'd2);
        check({p, "_erase0_addr"}, 64'((erase_addr.size() > 0) ? erase_addr[0] : 24'hFF_FFFF), 64'h1F_0000);
        check({p, "_erase1_addr"}, 64'((erase_addr.size() > 1) ? erase_addr[1] : 24'hFF_FFFF), 64'h1F_1000);
        check({p, "_progs"}, 64'(prog_count), 64'd32);
        check({p, "_prog_addr_errs"}, 64'(prog_bad), 64'd0);
        check({p, "_ram_reads"}, 64'(ram_count), 64'd8192);
        check({p, "_ram_addr_order_errs"}, 64'(ram_seq_bad), 64'd0);
        check({p, "_flash_data_errs"}, 64'(data_bad()), 64'd0);
        check({p, "_done_pulses"}, 64'(done_cnt), 64'd1);
        check({p, "_error"}, 64'(ERROR), 64'd0);
        check({p, "_busy_after"}, 64'(BUSY), 64'd0);
        check({p, "_erase2_ram_reads"}, 64'(e2_ram), 64'd4096);
        check({p, "_erase2_progs"}, 64'(e2_prog), 64'd16);
        check({p, "_erase2_after_poll_clear"}, 64'(e2_wip), 64'd0);
        check({p, "_wdata_stability_errs"}, 64'(stab_bad), 64'd0);
    endtask

    typedef struct {
        logic        start;
        logic        f_ack;
        logic [7:0]  f_rdata;
        logic        r_ack;
        logic [7:0]  r_rdata;
        logic        busy;
        logic        req;
        logic [1:0]  op;
        logic [23:0] faddr;
        logic        oe;
        logic [23:0] raddr;
    } vec_t;

    vec_t vt [14];
    bit   ok;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        mdl_en = 1'b0; clr_req = 1'b0; stuck = 1'b0; bp = 1'b0;
        START = 1'b0; RESET_n = 1'b0; busy_at_end = 1'b1;
        t_ram_ack = 1'b0; t_flash_ack = 1'b0; t_ram_rdata = 8'h00; t_flash_rdata = 8'h00;

        //           start ack  fstat  rack rdata  busy req op   flash_addr   oe  ram_addr
        vt[0]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 24'h00_0000, 1'b0, 24'h00_0000};
        vt[1]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 24'h00_0000, 1'b0, 24'h00_0000};
        vt[2]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 2'd1, 24'h1F_0000, 1'b0, 24'h00_0000};
        vt[3]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 2'd1, 24'h1F_0000, 1'b0, 24'h00_0000};
        vt[4]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 2'd1, 24'h1F_0000, 1'b0, 24'h00_0000};
        vt[5]  = '{1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 24'h00_0000, 1'b0, 24'h00_0000};
        vt[6]  = '{1'b0, 1'b1, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1, 2'd3, 24'h1F_0000, 1'b0, 24'h00_0000};
        vt[7]  = '{1'b0, 1'b1, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 24'h00_0000, 1'b0, 24'h00_0000};
        vt[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 2'd3, 24'h1F_0000, 1'b0, 24'h00_0000};
        vt[9]  = '{1'b0, 1'b1, 8'hFE, 1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 24'h00_0000, 1'b0, 24'h00_0000};
        vt[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 24'h00_0000, 1'b1, 24'h77_E000};
        vt[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h5A, 1'b1, 1'b0, 2'd0, 24'h00_0000, 1'b0, 24'h00_0000};
        vt[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 2'd0, 24'h00_0000, 1'b1, 24'h77_E001};
        vt[13] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 24'h00_0000, 1'b1, 24'h77_E001};

        repeat (3) @(negedge CLK);
        check("reset_ctrl_outputs", 64'({BUSY, DONE, ERROR, FLASH_REQ, FLASH_OP, RAM_OE}), 64'd0);
        check("reset_addrs", 64'({FLASH_ADDR, RAM_ADDR}), 64'd0);
        check("reset_wdata", 64'(FLASH_WDATA), 64'd0);
        RESET_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            @(negedge CLK);
            START = vt[i].start;
            t_flash_ack = vt[i].f_ack; t_flash_rdata = vt[i].f_rdata;
            t_ram_ack = vt[i].r_ack;   t_ram_rdata = vt[i].r_rdata;
            @(posedge CLK);
            #1;
            check($sformatf("vec%0d {busy,req,op,faddr,oe,raddr}", i),
                  64'({BUSY, FLASH_REQ, FLASH_OP, FLASH_ADDR, RAM_OE, RAM_ADDR}),
                  64'({vt[i].busy, vt[i].req, vt[i].op, vt[i].faddr, vt[i].oe, vt[i].raddr}));
        end
        @(negedge CLK);
        START = 1'b0; t_flash_ack = 1'b0; t_ram_ack = 1'b0;

        // Mid-FILL with RAM_OE high: reset must clear outputs with no clock edge.
        #2 RESET_n = 1'b0;
        #1;
        check("async_reset_oe_busy", 64'({RAM_OE, BUSY}), 64'd0);
        check("async_reset_ram_addr", 64'(RAM_ADDR), 64'd0);
        @(negedge CLK);
        RESET_n = 1'b1;

        // Nominal save with a stray START during page 5.
        clear_models();
        mdl_en = 1'b1;
        pulse_start();
        wait_end(40000, 1'b1, ok);
        check_save("nominal", ok);

        // Timeout: WIP never clears after the first erase.
        clear_models();
        stuck = 1'b1;
        pulse_start();
        wait_end(3000, 1'b0, ok);
        repeat (3) @(negedge CLK);
        check("timeout_seen", 64'(ok), 64'd1);
        check("timeout_error", 64'(ERROR), 64'd1);
        check("timeout_busy", 64'(BUSY), 64'd0);
        check("timeout_status_ops", 64'(status_count), 64'(PL) + 64'd1);
        check("timeout_progs", 64'(prog_count), 64'd0);
        check("timeout_erases", 64'(erase_count), 64'd1);
        check("timeout_done", 64'(done_cnt), 64'd0);

        clear_models();
        stuck = 1'b0;
        @(negedge CLK); START = 1'b1;
        @(negedge CLK); START = 1'b0;
        check("restart_error_cleared", 64'(ERROR), 64'd0);
        check("restart_busy", 64'(BUSY), 64'd1);
        ok = 1'b0;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge CLK);
            if (erase_count > 0) ok = 1'b1;
        end
        check("restart_erase_addr", 64'((erase_addr.size() > 0) ? erase_addr[0] : 24'hFF_FFFF), 64'h1F_0000);

        // Reset while page 10 is being programmed.
        ok = 1'b0;
        for (int c = 0; c < 15000 && !ok; c++) begin
            @(negedge CLK);
            if (FLASH_REQ && FLASH_OP == 2'd2 && FLASH_ADDR == 24'h1F_0A00 && prog_rd >= 100) ok = 1'b1;
        end
        check("reached_page10_prog", 64'(ok), 64'd1);
        #2 RESET_n = 1'b0;
        #1;
        check("midprog_reset_req_oe_busy", 64'({FLASH_REQ, RAM_OE, BUSY}), 64'd0);
        check("midprog_reset_op", 64'(FLASH_OP), 64'd0);
        repeat (2) @(negedge CLK);
        RESET_n = 1'b1;
        repeat (2) @(negedge CLK);
        check("post_reset_ctrl_idle", 64'({BUSY, DONE, ERROR, FLASH_REQ, FLASH_OP, RAM_OE}), 64'd0);
        check("post_reset_data_idle", 64'({FLASH_ADDR, RAM_ADDR, FLASH_WDATA}), 64'd0);

        // Full save under random RAM latency and RD gaps.
        clear_models();
        bp = 1'b1;
        pulse_start();
        wait_end(60000, 1'b0, ok);
        check_save("backpressure", ok);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
